pf_ccc_adc_lock_sequencer: RTL
==============================

// Module: pf_ccc_adc_lock_sequencer
// PURPOSE
// - Power-up and lock supervisor for the ADC fabric-clock PLL (PF_CCC_ADC).
// - Drives the PLL POWERDOWN_N input and qualifies its LOCK output.
// - Holds the ADC-domain reset until lock has been stable for a set time.
// - Retries on lock timeout, latches FAULT after a set number of retries, and re-sequences on loss of lock.
// - Clocked from the free-running PLL reference clock, never from the PLL output.
// PARAMETERS
// - PWRDN_CYCLES        16     cycles POWERDOWN_N is held low before each attempt (>=2)
// - LOCK_TIMEOUT        65535  cycles allowed in WAIT_LOCK before the attempt is declared failed (>=4)
// - LOCK_STABLE_CYCLES  1024   consecutive synchronised-lock cycles required before release (>=1)
// - MAX_RETRIES         3      failed attempts tolerated before FAULT (1..255)
// - CNT_W is a localparam = $clog2(max of the three cycle params)+1
// PORTS
// - CLK              in   1  PLL reference clock; all logic on the rising edge
// - RESET            in   1  synchronous, active-high
// - ENABLE           in   1  1 = request the PLL running; 0 = power the PLL down
// - PLL_LOCK         in   1  raw PLL lock, asynchronous; 2-flop synchronised internally -> lock_s
// - PLL_POWERDOWN_N  out  1  to PLL POWERDOWN_N
// - ADC_RESET_N      out  1  reset for the ADC clock domain; consumer re-synchronises it
// - READY            out  1  PLL locked and qualified
// - FAULT            out  1  retries exhausted
// - RETRY_CNT        out  8  failed attempts in the current sequence
// - STATE            out  3  current state encoding, for debug
// BEHAVIOUR
// - All outputs are registered.
// - Values while RESET=1 and one cycle after: state=OFF, PLL_POWERDOWN_N=0, ADC_RESET_N=0, READY=0, FAULT=0, RETRY_CNT=0, cnt=0, sync flops=0.
// - States: OFF=0, PWRDN=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5. Codes 6-7 go to OFF.
// - Priority: RESET, then ENABLE=0 (any state other than OFF goes to OFF next cycle and RETRY_CNT clears), then the per-state rules below.
// - OFF: PLL_POWERDOWN_N=0. ENABLE=1 -> PWRDN with cnt=0.
// - PWRDN: PLL_POWERDOWN_N=0 for exactly PWRDN_CYCLES cycles (cnt 0..PWRDN_CYCLES-1), then WAIT_LOCK with cnt=0.
// - WAIT_LOCK: PLL_POWERDOWN_N=1.
//   - lock_s=1 -> STABLE with cnt=0. This takes priority over timeout in the same cycle.
//   - cnt==LOCK_TIMEOUT-1 with no lock: if RETRY_CNT+1 < MAX_RETRIES, then RETRY_CNT++ and go to PWRDN; otherwise RETRY_CNT++ and go to FAULT.
// - STABLE: cnt counts consecutive lock_s=1 cycles.
//   - lock_s=0 -> WAIT_LOCK with cnt=0; RETRY_CNT unchanged.
//   - cnt==LOCK_STABLE_CYCLES-1 with lock_s=1 -> RUN.
// - RUN: ADC_RESET_N=1, READY=1.
//   - lock_s=0 -> PWRDN. ADC_RESET_N=0 and READY=0 on that same edge. RETRY_CNT clears.
// - FAULT: FAULT=1, PLL_POWERDOWN_N=0, ADC_RESET_N=0. The state is held until ENABLE=0.
// - ADC_RESET_N and READY are 1 only in RUN. FAULT is 1 only in FAULT.
// - Latency: a PLL_LOCK rise is seen by the FSM 2 cycles later (synchroniser). RUN is entered LOCK_STABLE_CYCLES+3 cycles after the PLL_LOCK rise.
// - Counters never wrap. cnt always resets on a state change. RETRY_CNT saturates at MAX_RETRIES.
// - A reset mid-sequence always powers the PLL down on the next edge.
// CONFIGURATION
// - PF_CCC_ADC_LOCK_LOSS_CNT_EN defined:
//   - adds output LOCK_LOSS_CNT[7:0], reset 0;
//   - increments on each RUN->PWRDN transition and saturates at 255;
//   - cleared only by RESET, not by ENABLE=0.
// - Not defined: the port and the counter are absent. All other behaviour is identical.
// TESTING (bench params: PWRDN_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2)
// - Nominal lock: RESET released, ENABLE=1, PLL_LOCK rises 10 cycles after POWERDOWN_N rises.
//   -> POWERDOWN_N low for exactly 4 cycles; READY=1 and ADC_RESET_N=1 exactly 11 cycles after the PLL_LOCK rise.
// - Timeout and retry: PLL_LOCK held 0.
//   -> two 20-cycle WAIT_LOCK windows, each preceded by a 4-cycle powerdown; then FAULT=1, RETRY_CNT=2, POWERDOWN_N=0.
//   -> FAULT clears 1 cycle after ENABLE=0.
// - Glitch in STABLE: PLL_LOCK drops for 1 cycle after 5 stable cycles.
//   -> return to WAIT_LOCK, RETRY_CNT=0; the next clean lock reaches RUN after a full 8 stable cycles.
// - Loss in RUN: PLL_LOCK drops while READY=1.
//   -> READY=0 and ADC_RESET_N=0 3 cycles after the drop; PWRDN entered; LOCK_LOSS_CNT=1 when the macro is defined.
// - Abort: ENABLE=0 in WAIT_LOCK at cnt=7, and separately RESET=1 in RUN.
//   -> both give STATE=OFF, POWERDOWN_N=0, ADC_RESET_N=0 on the next edge.
// - Simultaneous: lock_s rises in the cycle cnt==19 in WAIT_LOCK.
//   -> STABLE entered, RETRY_CNT unchanged.

Source files
------------

// File: rtl/pf_ccc_adc_lock_sequencer.sv
// Power-up and lock supervisor for the PF_CCC_ADC fabric-clock PLL, clocked from the PLL reference clock.
// Define PF_CCC_ADC_LOCK_LOSS_CNT_EN to add the LOCK_LOSS_CNT output (RUN->PWRDN event counter).
module pf_ccc_adc_lock_sequencer #(
    parameter int unsigned PWRDN_CYCLES       = 16,
    parameter int unsigned LOCK_TIMEOUT       = 65535,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       PLL_LOCK,
    output logic       PLL_POWERDOWN_N,
    output logic       ADC_RESET_N,
    output logic       READY,
    output logic       FAULT,
`ifdef PF_CCC_ADC_LOCK_LOSS_CNT_EN
    output logic [7:0] LOCK_LOSS_CNT,
`endif
    output logic [7:0] RETRY_CNT,
    output logic [2:0] STATE
);

    localparam int unsigned CYC_MAX_A = (PWRDN_CYCLES > LOCK_TIMEOUT) ? PWRDN_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CYC_MAX   = (CYC_MAX_A > LOCK_STABLE_CYCLES) ? CYC_MAX_A : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CYC_MAX) + 1;

    localparam logic [CNT_W-1:0] PWRDN_LAST   = CNT_W'(PWRDN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_PWRDN     = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_STABLE    = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [7:0]       retry_n;
    logic             lock_m;
    logic             lock_s;
    logic             retry_left;
    logic [7:0]       retry_inc;

    assign retry_left = ({1'b0, RETRY_CNT} + 9'd1) < 9'(MAX_RETRIES);
    assign retry_inc  = (RETRY_CNT < 8'(MAX_RETRIES)) ? RETRY_CNT + 8'd1 : RETRY_CNT;

    // Next-state, counter and retry bookkeeping; ENABLE=0 overrides every state.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        retry_n = RETRY_CNT;
        if (!ENABLE) begin
            state_n = S_OFF;
            cnt_n   = '0;
            retry_n = '0;
        end else begin
            case (state)
                S_OFF: begin
                    state_n = S_PWRDN;
                    cnt_n   = '0;
                end
                S_PWRDN: begin
                    if (cnt == PWRDN_LAST) begin
                        state_n = S_WAIT_LOCK;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_n = S_STABLE;
                        cnt_n   = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state_n = retry_left ? S_PWRDN : S_FAULT;
                        cnt_n   = '0;
                        retry_n = retry_inc;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_n = S_WAIT_LOCK;
                        cnt_n   = '0;
                    end else if (cnt == STABLE_LAST) begin
                        state_n = S_RUN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_n = S_PWRDN;
                        cnt_n   = '0;
                        retry_n = '0;
                    end
                end
                S_FAULT: begin
                    state_n = S_FAULT;
                end
                default: begin
                    state_n = S_OFF;
                    cnt_n   = '0;
                    retry_n = '0;
                end
            endcase
        end
    end

    // State, lock synchroniser and outputs decoded from the next state so they land with it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state           <= S_OFF;
            cnt             <= '0;
            lock_m          <= 1'b0;
            lock_s          <= 1'b0;
            RETRY_CNT       <= '0;
            PLL_POWERDOWN_N <= 1'b0;
            ADC_RESET_N     <= 1'b0;
            READY           <= 1'b0;
            FAULT           <= 1'b0;
        end else begin
            lock_m          <= PLL_LOCK;
            lock_s          <= lock_m;
            state           <= state_n;
            cnt             <= cnt_n;
            RETRY_CNT       <= retry_n;
            PLL_POWERDOWN_N <= (state_n == S_WAIT_LOCK) || (state_n == S_STABLE) || (state_n == S_RUN);
            ADC_RESET_N     <= (state_n == S_RUN);
            READY           <= (state_n == S_RUN);
            FAULT           <= (state_n == S_FAULT);
        end
    end

    assign STATE = state;

`ifdef PF_CCC_ADC_LOCK_LOSS_CNT_EN
    // Counts lock losses while running; survives ENABLE=0, cleared only by RESET.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            LOCK_LOSS_CNT <= '0;
        end else if (ENABLE && (state == S_RUN) && !lock_s && (LOCK_LOSS_CNT != 8'hFF)) begin
            LOCK_LOSS_CNT <= LOCK_LOSS_CNT + 8'd1;
        end
    end
`endif

endmodule
